// File: rtl/rails_sequencer.sv
// rtl/rails_sequencer.sv - rail-station frame source: LIFO station ops in, header + departure order out
// Optional auto-drain of the station after the last arrival: RAILS_SEQ_AUTO_DRAIN_EN
module rails_sequencer #(
    parameter int MAX_TRAINS = 10,
    parameter int DW         = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] n,
    input  logic          op_valid,
    input  logic          op,
    output logic          op_ready,
    output logic [DW-1:0] data,
    output logic          data_valid,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(MAX_TRAINS + 1);
    localparam logic [DW:0] MIN_N = (DW+1)'(3);
    localparam logic [DW:0] MAX_N = (DW+1)'(MAX_TRAINS);

    typedef enum logic [1:0] {IDLE, LOAD, SEND_HDR, SEND_SEQ} state_t;

    state_t        state, state_d;
    logic [DW-1:0] n_lat, n_lat_d;
    logic [CW-1:0] sp, sp_d;
    logic [CW-1:0] dcnt, dcnt_d;
    logic [CW-1:0] k, k_d;
    logic [DW:0]   next_train, next_train_d;
    logic [DW-1:0] data_d;
    logic          data_valid_d, busy_d, err_d, op_ready_d;
    logic          push, pop, drain, drain_d;

    logic [DW-1:0] stack [MAX_TRAINS];
    logic [DW-1:0] seq   [MAX_TRAINS];

    logic [DW:0] n_in_ext, n_ext;
    assign n_in_ext = {1'b0, n};
    assign n_ext    = {1'b0, n_lat};

`ifdef RAILS_SEQ_AUTO_DRAIN_EN
    // Once every train has arrived, the remaining stack empties itself one per cycle.
    assign drain   = (state == LOAD) && (next_train > n_ext) && (sp != '0);
    assign drain_d = (next_train_d > {1'b0, n_lat_d}) && (sp_d != '0);
`else
    assign drain   = 1'b0;
    assign drain_d = 1'b0;
`endif

    always_comb begin
        state_d      = state;
        n_lat_d      = n_lat;
        sp_d         = sp;
        dcnt_d       = dcnt;
        k_d          = k;
        next_train_d = next_train;
        data_d       = data;
        data_valid_d = 1'b0;
        err_d        = err;
        push         = 1'b0;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (n_in_ext >= MIN_N && n_in_ext <= MAX_N) begin
                        n_lat_d      = n;
                        sp_d         = '0;
                        dcnt_d       = '0;
                        next_train_d = (DW+1)'(1);
                        err_d        = 1'b0;
                        state_d      = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (drain) begin
                    pop = 1'b1;
                end else if (op_valid && op_ready) begin
                    if (!op) begin
                        if (next_train <= n_ext) begin
                            push = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        if (sp != '0) begin
                            pop = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                if (push) begin
                    sp_d         = sp + CW'(1);
                    next_train_d = next_train + (DW+1)'(1);
                end
                if (pop) begin
                    sp_d   = sp - CW'(1);
                    dcnt_d = dcnt + CW'(1);
                    if (dcnt_d == CW'(n_lat)) begin
                        state_d = SEND_HDR;
                    end
                end
            end
            SEND_HDR: begin
                data_d       = n_lat;
                data_valid_d = 1'b1;
                k_d          = '0;
                state_d      = SEND_SEQ;
            end
            SEND_SEQ: begin
                data_d       = seq[k];
                data_valid_d = 1'b1;
                k_d          = k + CW'(1);
                if (k == CW'(n_lat) - CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        op_ready_d = (state_d == LOAD) && !drain_d;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            n_lat      <= '0;
            sp         <= '0;
            dcnt       <= '0;
            k          <= '0;
            next_train <= (DW+1)'(1);
            data       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            op_ready   <= 1'b0;
        end else begin
            state      <= state_d;
            n_lat      <= n_lat_d;
            sp         <= sp_d;
            dcnt       <= dcnt_d;
            k          <= k_d;
            next_train <= next_train_d;
            data       <= data_d;
            data_valid <= data_valid_d;
            busy       <= busy_d;
            err        <= err_d;
            op_ready   <= op_ready_d;
        end
    end

    // Storage needs no reset: entries are always written before they are read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp] <= next_train[DW-1:0];
        end
        if (pop) begin
            seq[dcnt] <= stack[sp - CW'(1)];
        end
    end

endmodule

// File: tb/tb_rails_sequencer.sv
// tb/tb_rails_sequencer.sv - scoreboard bench for rails_sequencer with a queue-based station model
module tb_rails_sequencer;

    localparam int MAXT = 10;
    localparam int DW   = 4;

    logic          clk = 1'b0;
    logic          reset, start, op_valid, op;
    logic [DW-1:0] n;
    logic          op_ready, data_valid, busy, err;
    logic [DW-1:0] data;

    rails_sequencer #(.MAX_TRAINS(MAXT), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .n(n),
        .op_valid(op_valid), .op(op), .op_ready(op_ready),
        .data(data), .data_valid(data_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    bit prev_v = 1'b0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every valid word must match the head of the expected-frame queue.
    initial begin
        forever begin
            @(negedge clk);
            if (data_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got %0d expected no output at %0t", data, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(data) != e) begin
                        fails++;
                        $display("FAIL frame_word: got %0d expected %0d at %0t", data, e, $time);
                    end
                end
            end else if (prev_v && exp_q.size() != 0) begin
                check("frame_gap_words_left", exp_q.size(), 0);
            end
            prev_v = data_valid;
        end
    end

    task automatic do_start(input int nn);
        @(negedge clk);
        start = 1'b1;
        n     = DW'(nn);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_op(input bit o);
        int t = 0;
        @(negedge clk);
        while (!op_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("op_ready_wait", op_ready, 1);
        op_valid = 1'b1;
        op       = o;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || data_valid) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("frame_done_busy", busy, 0);
        check("frame_done_valid", data_valid, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic push_frame(input int nn, input int sq[$]);
        exp_q.push_back(nn);
        foreach (sq[j]) exp_q.push_back(sq[j]);
    endtask

    task automatic run_frame(input int nn, input int ops[$], input bit poke, input bit rst_mid);
        int stk[$];
        int sq[$];
        int nt  = 1;
        bit bad = 1'b0;
        do_start(nn);
        check("busy_after_start", busy, 1);
        check("err_cleared_by_start", err, 0);
        foreach (ops[i]) begin
`ifdef RAILS_SEQ_AUTO_DRAIN_EN
            if (nt > nn) break;
`endif
            if (ops[i] == 0) begin
                if (nt > nn) bad = 1'b1;
                else begin
                    stk.push_back(nt);
                    nt++;
                end
            end else begin
                if (stk.size() == 0) bad = 1'b1;
                else sq.push_back(stk.pop_back());
            end
            if (!bad && sq.size() == nn) push_frame(nn, sq);
            do_op(ops[i][0]);
            if (bad) begin
                check("err_on_illegal", err, 1);
                check("busy_on_illegal", busy, 0);
                check("op_ready_on_illegal", op_ready, 0);
                repeat (3) @(negedge clk);
                check("no_output_after_abort", exp_q.size(), 0);
                return;
            end
            if (sq.size() == nn) begin
                check("hdr_not_early", data_valid, 0);
                @(negedge clk);
                check("hdr_on_time", data_valid, 1);
                break;
            end
        end
        if (sq.size() < nn) begin
            while (stk.size() != 0) sq.push_back(stk.pop_back());
            push_frame(nn, sq);
        end
        if (poke) do_start(5);
        if (rst_mid) begin
            @(negedge clk);
            @(posedge clk);
            #2;
            reset = 1'b1;
            exp_q.delete();
            #1;
            check("reset_mid_valid", data_valid, 0);
            check("reset_mid_busy", busy, 0);
            check("reset_mid_data", data, 0);
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        wait_idle();
        check("err_after_frame", err, 0);
    endtask

    initial begin
        int q[$];
        reset    = 1'b1;
        start    = 1'b0;
        op_valid = 1'b0;
        op       = 1'b0;
        n        = '0;
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_valid", data_valid, 0);
        check("rst_op_ready", op_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        reset = 1'b0;

        q = {0, 0, 0, 0, 1, 1, 1, 0, 1, 1};
        run_frame(5, q, 1'b0, 1'b0);
        q = {0, 1, 0, 1, 0, 1};
        run_frame(3, q, 1'b0, 1'b0);
        q = {1};
        run_frame(4, q, 1'b0, 1'b0);
        q = {0, 1, 0, 0, 1, 1, 0, 1};
        run_frame(4, q, 1'b0, 1'b0);

        do_start(2);
        check("err_n2", err, 1);
        check("busy_n2", busy, 0);
        do_start(11);
        check("err_n11", err, 1);
        check("busy_n11", busy, 0);

        q = {0, 0, 1, 0, 1, 1};
        run_frame(3, q, 1'b1, 1'b0);

        q = {};
        for (int i = 0; i < 10; i++) q.push_back(0);
        for (int i = 0; i < 10; i++) q.push_back(1);
        run_frame(10, q, 1'b0, 1'b0);
        q = {};
        for (int i = 0; i < 11; i++) q.push_back(0);
        run_frame(10, q, 1'b0, 1'b0);

        q = {0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        run_frame(6, q, 1'b0, 1'b1);
        check("err_after_reset", err, 0);

`ifdef RAILS_SEQ_AUTO_DRAIN_EN
        q = {0, 0, 1, 0, 0};
        run_frame(4, q, 1'b0, 1'b0);
`endif

        for (int r = 0; r < 30; r++) begin
            int nn, ar, dp;
            nn = $urandom_range(MAXT, 3);
            ar = 0;
            dp = 0;
            q  = {};
            while (dp < nn) begin
                if (ar == dp && $urandom_range(15) == 0) begin
                    q.push_back(1);
                    break;
                end
                if (ar < nn && (ar == dp || $urandom_range(1) == 0)) begin
                    q.push_back(0);
                    ar++;
                end else begin
                    q.push_back(1);
                    dp++;
                end
            end
            run_frame(nn, q, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rails_sequencer.md
Name: rails_sequencer

Overview:
- Transmitter side of the rail-station protocol: turns a station operation stream (arrive/depart) into the serial frame consumed by the departure-order checker.
- Trains arrive in order 1..N and enter a LIFO station. Each depart op records the top train. Once N departures are recorded, the block bursts the frame: header N, then N train numbers, one per cycle.
- Used as the stimulus/source block in front of the checker in system and bench environments.

Parameters:
- MAX_TRAINS, 10, station depth, departure buffer depth and upper limit of n.
- DW, 4, width of train numbers and of the data bus.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle pulse; latches n and begins a frame; honoured only in IDLE.
- n  input  DW  train count, legal range 3..MAX_TRAINS.
- op_valid  input  1  operation present this cycle.
- op  input  1  0 = arrive (push next train), 1 = depart (pop top).
- op_ready  output  1  high in LOAD; an op is accepted when op_valid&op_ready at a rising edge.
- data  output  DW  frame word (header or train number).
- data_valid  output  1  data qualifier; high for exactly N+1 contiguous cycles per frame.
- busy  output  1  high in every state except IDLE.
- err  output  1  sticky error flag; cleared by the next accepted start or by reset.

Behaviour:
- All outputs are registered. Reset values: data=0, data_valid=0, op_ready=0, busy=0, err=0; state=IDLE; stack pointer sp=0; next_train=1; departure count dcnt=0.
- States: IDLE, LOAD, SEND_HDR, SEND_SEQ.
- IDLE, start=1:
  - n in 3..MAX_TRAINS: latch N=n, set sp=0, next_train=1, dcnt=0, clear err, go to LOAD.
  - n out of range: set err=1 and stay in IDLE.
- IDLE, start=0: hold; data_valid=0.
- LOAD, accepted arrive:
  - Legal only when next_train<=N. Then stack[sp]=next_train, sp+1, next_train+1.
- LOAD, accepted depart:
  - Legal only when sp>0. Then seq[dcnt]=stack[sp-1], sp-1, dcnt+1.
- LOAD, illegal op (arrive with next_train>N, or depart with sp==0): err=1, frame aborted, go to IDLE. No data is emitted.
- LOAD exit: the edge that accepts the depart making dcnt==N moves the block to SEND_HDR.
- SEND_HDR: the next edge drives data=N, data_valid=1 and moves to SEND_SEQ with read index k=0.
- SEND_SEQ: each edge drives data=seq[k], data_valid=1, k+1. After seq[N-1] is driven, go to IDLE. data_valid drops on the following edge.
- Frame timing: the first header cycle follows the final-depart edge by one cycle. There are no gaps between header and sequence.
- start while busy is ignored. It does not change err, N or state.
- op_valid outside LOAD is ignored; op_ready=0 there.
- Arithmetic: sp and dcnt range 0..MAX_TRAINS; next_train ranges 1..MAX_TRAINS+1 and needs DW+1 bits internally.
- Reset mid-operation (any state) returns to reset values immediately. A partially sent frame is truncated; data_valid falls asynchronously.

Optional Feature:
- Macro: RAILS_SEQ_AUTO_DRAIN_EN.
- Defined:
  - Once next_train>N (all trains arrived) and sp>0, the block pops one train per cycle automatically until dcnt==N.
  - op_ready=0 during auto-drain, and ops are ignored.
  - The arrive-past-N error cannot occur after the last arrival.
- Undefined: the host must issue every depart op explicitly; the illegal-op rules above apply unchanged.

Test Plan:
- start with n=5; ops A,A,A,A,D,D,D,A,D,D -> data_valid for 6 cycles with data 5,4,3,2,5,1; busy falls after the last word; err=0.
- start with n=3; ops A,D,A,D,A,D -> frame 3,1,2,3; header appears exactly 1 cycle after the edge accepting the third D.
- start with n=4; first op D -> err=1 on the next cycle, state IDLE, no data_valid. A later start with n=4 clears err.
- start with n=2, then start with n=11 -> err=1 each time, busy stays 0. start pulsed during SEND_SEQ is ignored and the frame completes unchanged.
- n=10; 10 arrivals then 10 departs -> frame 10,10,9,8,7,6,5,4,3,2,1. An 11th arrive instead of the first D sets err and aborts.
- Assert reset during SEND_SEQ of an n=6 frame -> data_valid=0 and busy=0 immediately. With RAILS_SEQ_AUTO_DRAIN_EN defined, n=4 and ops A,A,D,A,A -> frame 4,2,4,3,1 with no further ops.
